// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the main-memory arbiter: port indices and default memory size.
package mem_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEFAULT_SIZE_WORDS = 'h3800;
    localparam int WAIT_CNT_W         = 8;

    typedef enum logic [1:0] {
        WIN_IDLE = 2'd0,
        WIN_CPU  = 2'd1,
        WIN_AUX  = 2'd2
    } winner_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating age counter for a refused requester; force_o asserts once the
// requester has been refused MAX_WAIT consecutive cycles.
module starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  gnt_i,
    output logic                  force_o,
    output logic [WAIT_CNT_W-1:0] cnt_o
);

    localparam logic [WAIT_CNT_W-1:0] MAX_L = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i)
            cnt_d = '0;
        else if (cnt_q < MAX_L)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign force_o = (cnt_q == MAX_L);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port fixed-priority arbiter in front of the single-port main memory,
// with starvation relief for port 1 and word-address bounds checking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int SIZE_WORDS = DEFAULT_SIZE_WORDS,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    output logic                  m0_gnt,
    input  logic                  m0_write,
    input  logic [3:0]            m0_wmask,
    input  logic [31:0]           m0_wdata,
    input  logic                  m0_wgrubby,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rgrubby,
    output logic                  m0_err,

    input  logic                  m1_req,
    output logic                  m1_gnt,
    input  logic                  m1_write,
    input  logic [3:0]            m1_wmask,
    input  logic [31:0]           m1_wdata,
    input  logic                  m1_wgrubby,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rgrubby,
    output logic                  m1_err,

    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wgrubby,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rgrubby
);

    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH+1)'(SIZE_WORDS);

    winner_e                 win;
    logic                    force1;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    sel_write, sel_oor;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rsel_q, rsel_d;
    logic                    rpend_q, rpend_d;
    logic                    rerr_q, rerr_d;
    logic [31:0]             ret_data;
    logic                    ret_grubby;

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req_i   (m1_req),
        .gnt_i   (m1_gnt),
        .force_o (force1),
        .cnt_o   (wait_cnt)
    );

    always_comb begin
        win = WIN_IDLE;
        if (force1 && m1_req) win = WIN_AUX;
        else if (m0_req)      win = WIN_CPU;
        else if (m1_req)      win = WIN_AUX;
    end

    assign m0_gnt = (win == WIN_CPU);
    assign m1_gnt = (win == WIN_AUX);

    assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sel_write = m1_gnt ? m1_write : m0_write;
    assign sel_oor   = ({1'b0, sel_addr} >= SIZE_L);

    always_comb begin
        mem_write   = 1'b0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        mem_wgrubby = 1'b0;
        mem_addr    = addr_q;
        addr_d      = addr_q;
        rsel_d      = rsel_q;
        rpend_d     = 1'b0;
        rerr_d      = 1'b0;
        if (win != WIN_IDLE) begin
            // Out-of-range writes are granted but never reach the array.
            mem_write   = sel_write && !sel_oor;
            mem_wmask   = m1_gnt ? m1_wmask   : m0_wmask;
            mem_wdata   = m1_gnt ? m1_wdata   : m0_wdata;
            mem_wgrubby = m1_gnt ? m1_wgrubby : m0_wgrubby;
            mem_addr    = sel_addr;
            addr_d      = sel_addr;
            rsel_d      = m1_gnt ? PORT_AUX : PORT_CPU;
            rpend_d     = !sel_write;
            rerr_d      = sel_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rsel_q  <= PORT_CPU;
            rpend_q <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rsel_q  <= rsel_d;
            rpend_q <= rpend_d;
            rerr_q  <= rerr_d;
        end
    end

    // A range error returns zeros rather than whatever the memory produced.
    assign ret_data   = rerr_q ? 32'h0 : mem_rdata;
    assign ret_grubby = rerr_q ? 1'b0  : mem_rgrubby;

    assign m0_rvalid  = rpend_q && (rsel_q == PORT_CPU);
    assign m1_rvalid  = rpend_q && (rsel_q == PORT_AUX);
    assign m0_err     = rerr_q  && (rsel_q == PORT_CPU);
    assign m1_err     = rerr_q  && (rsel_q == PORT_AUX);
    assign m0_rdata   = m0_rvalid ? ret_data   : 32'h0;
    assign m1_rdata   = m1_rvalid ? ret_data   : 32'h0;
    assign m0_rgrubby = m0_rvalid ? ret_grubby : 1'b0;
    assign m1_rgrubby = m1_rvalid ? ret_grubby : 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; memory return data is driven by hand.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_write, m0_wgrubby, m0_rvalid, m0_rgrubby, m0_err;
    logic [3:0]  m0_wmask;
    logic [31:0] m0_wdata, m0_rdata;
    logic [13:0] m0_addr;
    logic        m1_req, m1_gnt, m1_write, m1_wgrubby, m1_rvalid, m1_rgrubby, m1_err;
    logic [3:0]  m1_wmask;
    logic [31:0] m1_wdata, m1_rdata;
    logic [13:0] m1_addr;
    logic        mem_write, mem_wgrubby, mem_rgrubby;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_rdata;
    logic [13:0] mem_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(14), .SIZE_WORDS('h3800), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_write(m0_write), .m0_wmask(m0_wmask),
        .m0_wdata(m0_wdata), .m0_wgrubby(m0_wgrubby), .m0_addr(m0_addr),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rgrubby(m0_rgrubby), .m0_err(m0_err),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_write(m1_write), .m1_wmask(m1_wmask),
        .m1_wdata(m1_wdata), .m1_wgrubby(m1_wgrubby), .m1_addr(m1_addr),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rgrubby(m1_rgrubby), .m1_err(m1_err),
        .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_wgrubby(mem_wgrubby), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rgrubby(mem_rgrubby)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 0);
        chk({tag, ".m0_rdata"},  m0_rdata,       0);
        chk({tag, ".m0_err"},    32'(m0_err),    0);
        chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 0);
        chk({tag, ".m1_rdata"},  m1_rdata,       0);
        chk({tag, ".m1_err"},    32'(m1_err),    0);
        chk({tag, ".mem_write"}, 32'(mem_write), 0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  0);
        chk({tag, ".wait_cnt"},  32'(dut.u_starve.cnt_q), 0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_write = 0; m0_wmask = 0; m0_wdata = 0; m0_wgrubby = 0; m0_addr = 0;
        m1_req = 0; m1_write = 0; m1_wmask = 0; m1_wdata = 0; m1_wgrubby = 0; m1_addr = 0;
        mem_rdata = 0; mem_rgrubby = 0;
        settle();
        chk_idle_outputs("reset");
        nxt(); rst = 1'b0;

        // Port 0 back-to-back reads
        nxt(); m0_req = 1; m0_addr = 14'h0010;
        settle();
        chk("p0.gnt0", 32'(m0_gnt), 1);
        chk("p0.addr0", 32'(mem_addr), 'h10);
        chk("p0.wr0", 32'(mem_write), 0);
        nxt(); m0_addr = 14'h0011; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("p0.gnt1", 32'(m0_gnt), 1);
        chk("p0.rv1", 32'(m0_rvalid), 1);
        chk("p0.rd1", m0_rdata, 32'hDEADBEEF);
        chk("p0.m1rv1", 32'(m1_rvalid), 0);
        chk("p0.m1rd1", m1_rdata, 0);
        nxt(); m0_req = 0; mem_rdata = 32'h12345678;
        settle();
        chk("p0.rv2", 32'(m0_rvalid), 1);
        chk("p0.rd2", m0_rdata, 32'h12345678);
        chk("p0.m1gnt2", 32'(m1_gnt), 0);
        chk("p0.addrhold", 32'(mem_addr), 'h11);
        nxt();
        settle();
        chk("p0.rv3", 32'(m0_rvalid), 0);
        chk("p0.rd3", m0_rdata, 0);

        // Both requesting: port 1 refused 8 cycles, granted on the 9th
        nxt(); m0_req = 1; m0_addr = 14'h0020; m1_req = 1; m1_addr = 14'h0021; mem_rdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("starve.m1gnt%0d", i), 32'(m1_gnt), (i == 8) ? 1 : 0);
            chk($sformatf("starve.m0gnt%0d", i), 32'(m0_gnt), (i == 8) ? 0 : 1);
            if (i == 8) chk("starve.cnt_sat", 32'(dut.u_starve.cnt_q), 8);
            if (i == 9) begin
                chk("starve.cnt_clr", 32'(dut.u_starve.cnt_q), 0);
                chk("starve.m1rv", 32'(m1_rvalid), 1);
                chk("starve.m0rv", 32'(m0_rvalid), 0);
            end
            nxt();
        end
        m0_req = 0; m1_req = 0;
        settle();
        chk("starve.tail_m0rv", 32'(m0_rvalid), 1);

        // Port 1 write with grubby, then read back
        nxt(); m1_req = 1; m1_write = 1; m1_addr = 14'h0100; m1_wmask = 4'b0101;
        m1_wdata = 32'hA5A5A5A5; m1_wgrubby = 1;
        settle();
        chk("wr.gnt", 32'(m1_gnt), 1);
        chk("wr.mem_write", 32'(mem_write), 1);
        chk("wr.mask", 32'(mem_wmask), 'b0101);
        chk("wr.data", mem_wdata, 32'hA5A5A5A5);
        chk("wr.grubby", 32'(mem_wgrubby), 1);
        chk("wr.addr", 32'(mem_addr), 'h100);
        nxt(); m1_req = 0; m1_write = 0; m1_wgrubby = 0;
        settle();
        chk("wr.no_rv", 32'(m1_rvalid), 0);
        chk("wr.no_err", 32'(m1_err), 0);
        chk("wr.idle_write", 32'(mem_write), 0);
        nxt(); m1_req = 1;
        nxt(); m1_req = 0; mem_rdata = 32'hA5A5A5A5; mem_rgrubby = 1;
        settle();
        chk("rd1.rv", 32'(m1_rvalid), 1);
        chk("rd1.data", m1_rdata, 32'hA5A5A5A5);
        chk("rd1.grubby", 32'(m1_rgrubby), 1);
        chk("rd1.m0grubby", 32'(m0_rgrubby), 0);

        // Out-of-range read at the first unpopulated word
        nxt(); m0_req = 1; m0_addr = 14'h3800; mem_rdata = 32'hFFFFFFFF;
        settle();
        chk("oor.gnt", 32'(m0_gnt), 1);
        chk("oor.mem_write", 32'(mem_write), 0);
        nxt(); m0_write = 1; m0_addr = 14'h3FFF;
        settle();
        chk("oor.rv", 32'(m0_rvalid), 1);
        chk("oor.rdata", m0_rdata, 0);
        chk("oor.rgrubby", 32'(m0_rgrubby), 0);
        chk("oor.err", 32'(m0_err), 1);
        chk("oorw.mem_write", 32'(mem_write), 0);
        chk("oorw.gnt", 32'(m0_gnt), 1);
        nxt(); m0_req = 1; m0_write = 0; m0_addr = 14'h37FF;
        settle();
        chk("oorw.err", 32'(m0_err), 1);
        chk("oorw.no_rv", 32'(m0_rvalid), 0);
        nxt(); m0_req = 0; mem_rdata = 32'hCAFEF00D;
        settle();
        chk("last.rv", 32'(m0_rvalid), 1);
        chk("last.data", m0_rdata, 32'hCAFEF00D);
        chk("last.err", 32'(m0_err), 0);

        // Interleave: port 0 then port 1
        nxt(); m0_req = 1; m0_addr = 14'h0020; mem_rgrubby = 0;
        nxt(); m0_req = 0; m1_req = 1; m1_addr = 14'h0030; mem_rdata = 32'h11111111;
        settle();
        chk("il.m0rv", 32'(m0_rvalid), 1);
        chk("il.m0rd", m0_rdata, 32'h11111111);
        chk("il.m1rv", 32'(m1_rvalid), 0);
        chk("il.m1rd", m1_rdata, 0);
        nxt(); m1_req = 0; mem_rdata = 32'h22222222;
        settle();
        chk("il.m1rv2", 32'(m1_rvalid), 1);
        chk("il.m1rd2", m1_rdata, 32'h22222222);
        chk("il.m0rv2", 32'(m0_rvalid), 0);

        // Reset mid-read
        nxt(); m0_req = 1; m0_addr = 14'h0040; m1_req = 1; m1_addr = 14'h0041;
        settle();
        chk("rst.gnt", 32'(m0_gnt), 1);
        nxt(); rst = 1; m0_req = 0; m1_req = 0; mem_rdata = 32'h33333333;
        #1;
        chk("rst.m0rv_now", 32'(m0_rvalid), 0);
        chk("rst.m0rd_now", m0_rdata, 0);
        nxt(); rst = 0;
        settle();
        chk_idle_outputs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
